// File: rtl/sram_colmux_param_pkg.sv
// sram_colmux_param_pkg: shared FSM state and sizing helper for the column-muxed SRAM
package sram_colmux_param_pkg;
    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;
    function automatic int addr_bits(input int rows, input int col_mux);
        return $clog2(rows) + $clog2(col_mux);
    endfunction
endpackage

// File: rtl/sram_colmux_param_clear_seq.sv
// sram_colmux_param_clear_seq: row counter and CLEAR/IDLE FSM that sweeps the array with INIT_VAL
module sram_colmux_param_clear_seq
    import sram_colmux_param_pkg::*;
#(
    parameter int ROWS = 16,
    localparam int ROW_BITS = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    output logic                clr_we,
    output logic [ROW_BITS-1:0] clr_row,
    output logic                busy,
    output logic                ready
);
    state_t              state;
    logic [ROW_BITS-1:0] row_cnt;
    always_ff @(posedge clk) begin
        if (reset || clear_req) begin
            state   <= CLEAR;
            row_cnt <= '0;
        end else if (state == CLEAR) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == ROW_BITS'(ROWS - 1)) state <= IDLE;
        end
    end
    assign busy    = state == CLEAR;
    assign clr_we  = busy;
    assign clr_row = row_cnt;
    assign ready   = state == IDLE && !clear_req;
endmodule

// File: rtl/sram_colmux_param.sv
// sram_colmux_param: single-port column-interleaved SRAM model with handshake, bit mask and clear sequencer
module sram_colmux_param
    import sram_colmux_param_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ROWS     = 16,
    parameter int COL_MUX  = 4,
    parameter bit INIT_VAL = 1'b0,
    localparam int ADDR_W  = addr_bits(ROWS, COL_MUX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] wmask,
    output logic              ready,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] data_out
);
    localparam int COL_BITS = $clog2(COL_MUX);
    localparam int ROW_BITS = $clog2(ROWS);
    // [i][c] of a row is physical bit i*COL_MUX+c, giving the bit interleave directly
    logic [DATA_W-1:0][COL_MUX-1:0] mem [ROWS];
    logic [ROW_BITS-1:0] row, clr_row;
    logic [COL_BITS-1:0] col;
    logic                clr_we, accept;
    assign row    = address[ADDR_W-1:COL_BITS];
    assign col    = address[COL_BITS-1:0];
    assign accept = req && ready && !reset;
    sram_colmux_param_clear_seq #(.ROWS(ROWS)) u_clear (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .clr_we(clr_we), .clr_row(clr_row), .busy(busy), .ready(ready)
    );
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_row] <= {(DATA_W*COL_MUX){INIT_VAL}};
        else if (accept && !rw)
            for (int i = 0; i < DATA_W; i++)
                if (wmask[i]) mem[row][i][col] <= data_in[i];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= accept && rw;
            if (accept && rw)
                for (int i = 0; i < DATA_W; i++) data_out[i] <= mem[row][i][col];
        end
    end
endmodule
